// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared segment constants, BCD decode table and scan FSM states.
package sevenseg_pkg;
   localparam int SEG_W = 7;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_LUT [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, SEG_BLANK,  SEG_BLANK,
      SEG_BLANK,  SEG_BLANK,  SEG_BLANK,  SEG_BLANK
   };
   typedef enum logic {ST_ON, ST_BLANK} state_t;
endpackage

// File: rtl/sevenseg_digit_dec.sv
// sevenseg_digit_dec: BCD nibble to active-low {a..g} segments, blank on non-decimal.
module sevenseg_digit_dec
   import sevenseg_pkg::*;
(
   input  logic [3:0]       bcd_i,
   output logic [SEG_W-1:0] seg_o
);
   assign seg_o = SEG_LUT[bcd_i];
endmodule

// File: rtl/sevenseg_scan_mux.sv
// sevenseg_scan_mux: multiplexed seven-segment scanner with dead-time; SEVENSEG_LEADING_ZERO_BLANK_EN blanks leading zeros.
module sevenseg_scan_mux
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 12000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_i,
   input  logic [4*NUM_DIGITS-1:0] value_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   output logic                    ready_o,
   output logic [SEG_W-1:0]        seg_o,
   output logic                    dp_o,
   output logic [NUM_DIGITS-1:0]   an_o
);
   localparam int IW   = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam int DMAX = REFRESH_DIV > BLANK_CYCLES ? REFRESH_DIV : BLANK_CYCLES;
   localparam int DW   = $clog2(DMAX);
   localparam int BT   = BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0;
   state_t                  state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d, idx_adv;
   logic [DW-1:0]           div_q, div_d;
   logic                    first_q, first_d, pending_q, pending_d;
   logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, disp_q, disp_d;
   logic [NUM_DIGITS-1:0]   sdp_q, sdp_d, ddp_q, ddp_d, an_q, an_d;
   logic [SEG_W-1:0]        seg_q, seg_d, dec_seg;
   logic                    dp_q, dp_d, term, advance, boundary, capture, lz_hit;
   logic [3:0]              nib;
   assign nib = disp_q[{idx_q, 2'b00} +: 4];
   sevenseg_digit_dec u_dec (.bcd_i(nib), .seg_o(dec_seg));
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] lz;
   logic                  zero_above;
   always_comb begin
      lz = '0;
      zero_above = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_above = zero_above & (disp_q[4*k +: 4] == 4'd0);
         lz[k] = zero_above;
      end
      lz_hit = (idx_q != '0) && lz[idx_q];
   end
`else
   assign lz_hit = 1'b0;
`endif
   always_comb begin
      term     = state_q == ST_ON ? div_q == DW'(REFRESH_DIV - 1) : div_q == DW'(BT);
      advance  = state_q == ST_BLANK && term;
      // the first digit after reset is 0 rather than 0+1
      idx_adv  = first_q || idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
      boundary = advance && idx_adv == '0;
      state_d  = term ? (state_q == ST_ON ? ST_BLANK : ST_ON) : state_q;
      div_d    = term ? '0 : div_q + 1'b1;
      idx_d    = advance ? idx_adv : idx_q;
      first_d  = first_q && !advance;
      capture  = load_i && !pending_q;
      shadow_d = capture ? value_i : shadow_q;
      sdp_d    = capture ? dp_i : sdp_q;
      pending_d = capture || (pending_q && !boundary);
      disp_d   = boundary && pending_q ? shadow_q : disp_q;
      ddp_d    = boundary && pending_q ? sdp_q : ddp_q;
      seg_d    = state_q == ST_ON && !lz_hit ? dec_seg : SEG_BLANK;
      dp_d     = !(state_q == ST_ON && ddp_q[idx_q]);
      an_d     = state_q == ST_ON ? ~(NUM_DIGITS'(1) << idx_q) : '1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_BLANK;
         idx_q     <= '0;
         div_q     <= '0;
         first_q   <= 1'b1;
         pending_q <= 1'b0;
         shadow_q  <= '0;
         sdp_q     <= '0;
         disp_q    <= '0;
         ddp_q     <= '0;
         seg_q     <= SEG_BLANK;
         dp_q      <= 1'b1;
         an_q      <= '1;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         div_q     <= div_d;
         first_q   <= first_d;
         pending_q <= pending_d;
         shadow_q  <= shadow_d;
         sdp_q     <= sdp_d;
         disp_q    <= disp_d;
         ddp_q     <= ddp_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         an_q      <= an_d;
      end
   end
   assign ready_o = !pending_q;
   assign seg_o   = seg_q;
   assign dp_o    = dp_q;
   assign an_o    = an_q;
endmodule
